sseg_scan_nx: RTL and testbench

SSEG_SCAN_NX -- requirements
Module: sseg_scan_nx

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/sseg_hex_decode.sv | 14 +
 rtl/sseg_scan_nx.sv | 150 +++++++++++++++
 tb/tb_sseg_scan_nx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants for the multiplexed seven-segment scanner
package sseg_pkg;

  // PWM phases per digit slot; phase 0 is always dark
  localparam int PHASES = 16;

  // Active-low drive levels for anodes, cathodes and decimal point
  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Active-low hex glyphs, index 0 = segment a ... index 6 = segment g
  localparam logic [0:6] HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/sseg_hex_decode.sv
// rtl/sseg_hex_decode.sv - combinational 4-bit to active-low seven-segment glyph
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [0:6] seg_o
);

  // Straight table lookup; glyph polarity is already active-low
  always_comb begin
    seg_o = HEX_SEG[nibble_i];
  end

endmodule

// File: rtl/sseg_scan_nx.sv
// rtl/sseg_scan_nx.sv - multiplexed hex display scanner with PWM, blanking and blink
module sseg_scan_nx
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_HZ       = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [3:0]              bright,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int DIV_PWM = CLK_HZ / (SCAN_HZ * PHASES);
  localparam int DIV_W   = (DIV_PWM > 1) ? $clog2(DIV_PWM) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (DIV_PWM < 1) begin : g_bad_div
    $error("sseg_scan_nx: CLK_HZ too low for SCAN_HZ (DIV_PWM < 1)");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("sseg_scan_nx: NUM_DIGITS must be 1..8");
  end

  logic [DIV_W-1:0]          div_q, div_d;
  logic [3:0]                phase_q, phase_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [FC_W-1:0]           fc_q, fc_d;
  logic                      blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0]   value_s_q, value_s_d;
  logic [NUM_DIGITS-1:0]     dp_s_q, dp_s_d;
  logic                      blank_lz_s_q, blank_lz_s_d;
  logic [NUM_DIGITS-1:0]     blink_en_s_q, blink_en_s_d;
  logic [NUM_DIGITS-1:0]     an_q, an_d;
  logic [0:6]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      frame_done_q, frame_done_d;

  logic       tick, slot_end, frame_end;
  logic [3:0] sel_nib;
  logic [0:6] dec_seg;
  logic       upper_nz, lz_blank, blink_blank, lit;

  assign tick      = (div_q == DIV_W'(DIV_PWM - 1));
  assign slot_end  = tick && (phase_q == 4'(PHASES - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign sel_nib   = value_s_q[{idx_q, 2'b00} +: 4];

  sseg_hex_decode u_dec (
    .nibble_i (sel_nib),
    .seg_o    (dec_seg)
  );

  // Divider, phase, digit index, frame/blink counters and frame-boundary shadow capture
  always_comb begin
    div_d        = tick ? '0 : div_q + 1'b1;
    phase_d      = tick ? phase_q + 4'd1 : phase_q;
    idx_d        = idx_q;
    fc_d         = fc_q;
    blink_d      = blink_q;
    value_s_d    = value_s_q;
    dp_s_d       = dp_s_q;
    blank_lz_s_d = blank_lz_s_q;
    blink_en_s_d = blink_en_s_q;
    frame_done_d = frame_end;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      value_s_d    = value;
      dp_s_d       = dp_in;
      blank_lz_s_d = blank_lz;
      blink_en_s_d = blink_en;
      if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
        fc_d    = '0;
        blink_d = ~blink_q;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  // Leading-zero test: is any nibble at or above the selected digit non-zero
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_q) && value_s_q[4*j +: 4] != 4'h0) upper_nz = 1'b1;
    end
  end

  // Display drive for the selected digit, taken only from shadow copies
  always_comb begin
    lz_blank    = blank_lz_s_q && (idx_q != '0) && !upper_nz;
    blink_blank = blink_q && blink_en_s_q[idx_q];
    lit         = (phase_q != 4'd0) && (phase_q <= bright) && !lz_blank && !blink_blank;
    an_d        = {NUM_DIGITS{SEG_OFF}};
    if (lit) an_d[idx_q] = SEG_ON;
    seg_d       = dec_seg;
    dp_d        = ~dp_s_q[idx_q];
  end

  // State and registered outputs; reset blanks the display immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      phase_q      <= '0;
      idx_q        <= '0;
      fc_q         <= '0;
      blink_q      <= 1'b0;
      value_s_q    <= '0;
      dp_s_q       <= '0;
      blank_lz_s_q <= 1'b0;
      blink_en_s_q <= '0;
      an_q         <= {NUM_DIGITS{SEG_OFF}};
      seg_q        <= SEG_BLANK;
      dp_q         <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      fc_q         <= fc_d;
      blink_q      <= blink_d;
      value_s_q    <= value_s_d;
      dp_s_q       <= dp_s_d;
      blank_lz_s_q <= blank_lz_s_d;
      blink_en_s_q <= blink_en_s_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_nx.sv
// tb/tb_sseg_scan_nx.sv - directed self-checking bench for sseg_scan_nx
module tb_sseg_scan_nx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  bright = 4'd15;
  logic [3:0]  blink_en = 4'h0;
  logic [0:6]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  int         lowcnt   [4];
  int         firstlow [4];
  logic [0:6] segv     [4];
  logic       dpv      [4];
  int         bad;
  int         fd_err;
  logic [0:6] exp_seg  [4];
  int         exp_low  [4];

  sseg_scan_nx #(
    .NUM_DIGITS   (4),
    .CLK_HZ       (3200),
    .SCAN_HZ      (100),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .bright     (bright),
    .blink_en   (blink_en),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_fd();
    int g;
    g = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_fd: frame_done=%b after %0d clocks, required 1", frame_done, g);
    end
  endtask

  // Caller is at the negedge of a frame_done cycle; samples the 128 cycles of one frame.
  task automatic capture_frame(input int chg_n, input logic [15:0] chg_val);
    int d;
    int off;
    logic [3:0] ea;
    bad    = 0;
    fd_err = 0;
    for (int k = 0; k < 4; k++) begin
      lowcnt[k]   = 0;
      firstlow[k] = -1;
      segv[k]     = 7'b1111111;
      dpv[k]      = 1'b1;
    end
    for (int n = 1; n <= 128; n++) begin
      @(negedge clk);
      if (n == chg_n) value = chg_val;
      d   = (n - 1) / 32;
      off = (n - 1) % 32;
      if (off == 16) begin
        segv[d] = seg;
        dpv[d]  = dp;
      end
      if (an != 4'hF) begin
        ea = ~(4'b0001 << d);
        if (an != ea) bad++;
        else begin
          lowcnt[d]++;
          if (firstlow[d] < 0) firstlow[d] = off;
        end
      end
      if (frame_done !== (n == 128)) fd_err++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b required 1111", an); end
    n_checks++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b required 1111111", seg); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp: got %b required 1", dp); end
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b required 0", frame_done); end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (e < 3 && an !== 4'hF) begin
        n_fail++; $display("FAIL reset_release_dark e%0d: got %b required 1111", e, an);
      end else if (e == 3 && an !== 4'b1110) begin
        n_fail++; $display("FAIL reset_release_phase1: got %b required 1110", an);
      end
    end
    n_checks++;
    if (seg !== 7'b0000001) begin n_fail++; $display("FAIL reset_shadow_seg: got %b required 0000001", seg); end
  endtask

  task automatic test_scan();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin
        value = 16'h1234; dp_in = 4'b0101;
        exp_seg[0] = 7'b1001100; exp_seg[1] = 7'b0000110;
        exp_seg[2] = 7'b0010010; exp_seg[3] = 7'b1001111;
      end else begin
        value = 16'h89EF; dp_in = 4'b1010;
        exp_seg[0] = 7'b0111000; exp_seg[1] = 7'b0110000;
        exp_seg[2] = 7'b0000100; exp_seg[3] = 7'b0000000;
      end
      bright = 4'd15; blank_lz = 1'b0; blink_en = 4'h0;
      wait_fd();
      capture_frame(0, 16'h0);
      for (int d = 0; d < 4; d++) begin
        n_checks++;
        if (segv[d] !== exp_seg[d]) begin
          n_fail++; $display("FAIL scan_seg v%0d d%0d: got %b required %b", v, d, segv[d], exp_seg[d]);
        end
        n_checks++;
        if (lowcnt[d] != 30) begin
          n_fail++; $display("FAIL scan_duty v%0d d%0d: got %0d required 30", v, d, lowcnt[d]);
        end
        n_checks++;
        if (firstlow[d] != 2) begin
          n_fail++; $display("FAIL scan_first_lit v%0d d%0d: got %0d required 2", v, d, firstlow[d]);
        end
        n_checks++;
        if (dpv[d] !== ~dp_in[d]) begin
          n_fail++; $display("FAIL scan_dp v%0d d%0d: got %b required %b", v, d, dpv[d], ~dp_in[d]);
        end
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL scan_anode_select v%0d: %0d bad samples, required 0", v, bad); end
      n_checks++;
      if (fd_err != 0) begin n_fail++; $display("FAIL scan_frame_done v%0d: %0d bad samples, required 0", v, fd_err); end
    end
  endtask

  task automatic test_blanking();
    bright = 4'd15; blank_lz = 1'b1; blink_en = 4'h0; dp_in = 4'h0;
    for (int v = 0; v < 4; v++) begin
      exp_seg[0] = 7'b0000001; exp_seg[1] = 7'b0000001;
      exp_seg[2] = 7'b0000001; exp_seg[3] = 7'b0000001;
      case (v)
        0: begin
          value = 16'h0050; exp_seg[1] = 7'b0100100;
          exp_low[0] = 30; exp_low[1] = 30; exp_low[2] = 0; exp_low[3] = 0;
        end
        1: begin
          value = 16'h0000;
          exp_low[0] = 30; exp_low[1] = 0; exp_low[2] = 0; exp_low[3] = 0;
        end
        2: begin
          value = 16'h0100; exp_seg[2] = 7'b1001111;
          exp_low[0] = 30; exp_low[1] = 30; exp_low[2] = 30; exp_low[3] = 0;
        end
        default: begin
          value = 16'h1000; exp_seg[3] = 7'b1001111;
          exp_low[0] = 30; exp_low[1] = 30; exp_low[2] = 30; exp_low[3] = 30;
        end
      endcase
      wait_fd();
      capture_frame(0, 16'h0);
      for (int d = 0; d < 4; d++) begin
        n_checks++;
        if (lowcnt[d] != exp_low[d]) begin
          n_fail++; $display("FAIL blank_duty v%0d d%0d: got %0d required %0d", v, d, lowcnt[d], exp_low[d]);
        end
        n_checks++;
        if (segv[d] !== exp_seg[d]) begin
          n_fail++; $display("FAIL blank_seg v%0d d%0d: got %b required %b", v, d, segv[d], exp_seg[d]);
        end
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL blank_anode_select v%0d: %0d bad samples, required 0", v, bad); end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    int b;
    int el;
    int ef;
    value = 16'h1234; blank_lz = 1'b0; blink_en = 4'h0;
    for (int v = 0; v < 3; v++) begin
      case (v)
        0:       begin b = 4; el = 8; ef = 2;  end
        1:       begin b = 1; el = 2; ef = 2;  end
        default: begin b = 0; el = 0; ef = -1; end
      endcase
      bright = 4'(b);
      wait_fd();
      capture_frame(0, 16'h0);
      for (int d = 0; d < 4; d++) begin
        n_checks++;
        if (lowcnt[d] != el) begin
          n_fail++; $display("FAIL pwm_duty bright%0d d%0d: got %0d required %0d", b, d, lowcnt[d], el);
        end
        n_checks++;
        if (firstlow[d] != ef) begin
          n_fail++; $display("FAIL pwm_first_lit bright%0d d%0d: got %0d required %0d", b, d, firstlow[d], ef);
        end
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL pwm_anode_select bright%0d: %0d bad samples, required 0", b, bad); end
    end
    bright = 4'd15;
  endtask

  task automatic test_tearing();
    value = 16'h1234; bright = 4'd15; blank_lz = 1'b0; blink_en = 4'h0;
    wait_fd();
    capture_frame(40, 16'hABCD);
    exp_seg[0] = 7'b1001100; exp_seg[1] = 7'b0000110;
    exp_seg[2] = 7'b0010010; exp_seg[3] = 7'b1001111;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (segv[d] !== exp_seg[d]) begin
        n_fail++; $display("FAIL tear_old_frame d%0d: got %b required %b", d, segv[d], exp_seg[d]);
      end
    end
    capture_frame(0, 16'h0);
    exp_seg[0] = 7'b1000010; exp_seg[1] = 7'b0110001;
    exp_seg[2] = 7'b1100000; exp_seg[3] = 7'b0001000;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (segv[d] !== exp_seg[d]) begin
        n_fail++; $display("FAIL tear_new_frame d%0d: got %b required %b", d, segv[d], exp_seg[d]);
      end
    end
    n_checks++;
    if (fd_err != 0) begin n_fail++; $display("FAIL tear_frame_done: %0d bad samples, required 0", fd_err); end
  endtask

  task automatic test_reset_mid();
    value = 16'h1234; bright = 4'd15; blank_lz = 1'b0; blink_en = 4'h0;
    wait_fd();
    repeat (40) @(negedge clk);
    n_checks++;
    if (an !== 4'b1101) begin n_fail++; $display("FAIL rstmid_before: got %b required 1101", an); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (an !== 4'hF) begin n_fail++; $display("FAIL rstmid_an: got %b required 1111", an); end
    n_checks++;
    if (seg !== 7'b1111111) begin n_fail++; $display("FAIL rstmid_seg: got %b required 1111111", seg); end
    n_checks++;
    if (dp !== 1'b1) begin n_fail++; $display("FAIL rstmid_dp: got %b required 1", dp); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      n_checks++;
      if (e < 3 && an !== 4'hF) begin
        n_fail++; $display("FAIL rstmid_release_dark e%0d: got %b required 1111", e, an);
      end else if (e == 3 && an !== 4'b1110) begin
        n_fail++; $display("FAIL rstmid_release_phase1: got %b required 1110", an);
      end
    end
  endtask

  task automatic test_blink();
    value = 16'h1234; bright = 4'd15; blank_lz = 1'b0; blink_en = 4'b0001;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_fd();
    for (int f = 1; f <= 4; f++) begin
      capture_frame(0, 16'h0);
      for (int d = 0; d < 4; d++) begin
        exp_low[d] = (d == 0 && (f == 2 || f == 3)) ? 0 : 30;
        n_checks++;
        if (lowcnt[d] != exp_low[d]) begin
          n_fail++; $display("FAIL blink_duty frame%0d d%0d: got %0d required %0d", f, d, lowcnt[d], exp_low[d]);
        end
      end
      n_checks++;
      if (segv[0] !== 7'b1001100) begin
        n_fail++; $display("FAIL blink_seg frame%0d: got %b required 1001100", f, segv[0]);
      end
    end
    blink_en = 4'h0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_pwm();
    test_tearing();
    test_reset_mid();
    test_blink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
